mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access controller for the MEM stage of the 5-stage MIPS pipeline. It consumes the MEM-side outputs of the EX/MEM pipeline register and performs loads and stores against a handshaked data memory. Byte and halfword accesses use lane steering, store-data replication and sign/zero extension. While an access is in flight it stalls the pipeline registers, then presents the load result to MEM/WB.

## Interface
Parameters:
- ADDR_W, 32, byte-address width driven on DM_Addr.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-low (Rst==0 resets on the rising edge of Clk).
- MEM_MemRead  in  1  load request.
- MEM_MemWrite  in  1  store request.
- MEM_ALUResult  in  32  effective byte address.
- MEM_ReadData2  in  32  store data, right-justified.
- MEM_Datatype  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
- MEM_Instruction  in  32  instruction word. Bit 28 = 1 selects a zero-extended load (lbu/lhu).
- DM_Req  out  1  memory request, registered.
- DM_We  out  1  write enable, qualified by DM_Req.
- DM_Addr  out  ADDR_W  word-aligned address (low 2 bits forced to 0).
- DM_ByteEn  out  4  byte-lane enables.
- DM_WData  out  32  lane-replicated store data.
- DM_RData  in  32  read data, valid only when DM_Ack==1.
- DM_Ack  in  1  one-cycle completion pulse.
- MEM_ReadData  out  32  extended load result, registered.
- Stall  out  1  combinational. Holds Ld low on the PC, IF/ID, ID/EX and EX/MEM registers.
- Misaligned  out  1  combinational misalignment flag.

## Operation
- The unit has an access when (MEM_MemRead | MEM_MemWrite) & !Misaligned.
  - If both request bits are set, the access is a store and the read is ignored.
- Misaligned = (half & addr[0]) | (word & addr[1:0]!=0), qualified by MemRead|MemWrite. A misaligned request issues no memory request, raises no stall, and leaves MEM_ReadData unchanged.
- Lane steering is little-endian: byte k = bits [8k+7:8k], selected by addr[1:0].
  - Byte: ByteEn = 1<<addr[1:0]; WData = {4{rd2[7:0]}}.
  - Half: ByteEn = addr[1] ? 1100 : 0011; WData = {2{rd2[15:0]}}.
  - Word: ByteEn = 1111; WData = rd2.
- On a load, the selected lane is extracted and extended: sign-extended when Instruction[28]==0, zero-extended otherwise.
- State machine:
  - IDLE: when an access is present, latch DM_Addr, DM_We, DM_ByteEn and DM_WData, set DM_Req, and go to REQ.
  - REQ: hold DM_Req and all DM_* outputs stable until DM_Ack.
    - On DM_Ack, clear DM_Req.
    - On a load, register the extended result into MEM_ReadData.
    - Go to DONE.
  - DONE: always returns to IDLE on the next clock.
- Stall = access & (state != DONE).
- DM_Ack outside REQ is ignored.

## Timing
- Reset values: state IDLE; DM_Req 0, DM_We 0, DM_Addr 0, DM_ByteEn 0, DM_WData 0, MEM_ReadData 0.
  - Stall and Misaligned follow their inputs combinationally.
- Reset in REQ abandons the access: DM_Req drops on the reset edge, and a later ack is ignored.
- Access presented in cycle t (IDLE):
  - Stall=1 in cycle t.
  - DM_Req=1 from cycle t+1.
  - Ack in cycle t+k (k≥1) gives DONE in t+k+1. Stall=0 in that cycle and MEM_ReadData is valid.
  - The pipeline advances at the end of t+k+1.
  - Minimum 3 cycles per memory instruction.
- Non-memory instructions never stall. The following instruction's access is recognised in the IDLE cycle after DONE.
- DM_* outputs must not change while DM_Req=1 and no ack has been received.

## Structure
- Package mem_pkg holds:
  - Datatype constants DT_WORD=2'b00, DT_HALF=2'b01, DT_BYTE=2'b10.
  - State encoding IDLE/REQ/DONE.
  - The unsigned-bit index, UNSIGNED_BIT=28.
- Sub-module mem_lane_align (combinational) computes ByteEn, replicated WData and the extended load data from addr[1:0], the datatype and the unsigned bit. It is instantiated once and shared by the store and load paths.
- The top level holds the FSM, the DM_* output registers and the MEM_ReadData register.

## Test plan
- Load word, addr 0x100, ack one cycle after DM_Req, DM_RData 0xDEADBEEF:
  - DM_Addr 0x100, ByteEn 1111.
  - Stall high for exactly 2 cycles.
  - MEM_ReadData 0xDEADBEEF in DONE.
- lb, addr 0x103, RData 0x80FF0000: ByteEn 1000, MEM_ReadData 0xFFFFFF80. The same access as lbu (bit 28=1) gives 0x00000080.
- sh, addr 0x202, ReadData2 0x1234ABCD: DM_We 1, DM_Addr 0x200, ByteEn 1100, WData 0xABCDABCD.
- Load word, addr 0x101:
  - Misaligned=1, DM_Req stays 0, Stall 0.
  - MEM_ReadData keeps its previous value.
- Ack delayed 5 cycles:
  - DM_Addr, ByteEn and WData stable throughout.
  - Stall high for 6 cycles.
  - A spurious ack in IDLE has no effect.
- Rst=0 asserted while in REQ: next edge gives DM_Req 0, MEM_ReadData 0, state IDLE. An ack arriving after reset changes nothing.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data-memory access unit: access sizes,
// controller states and the instruction bit that selects zero-extended loads.
package mem_pkg;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    localparam int UNSIGNED_BIT = 28;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for sub-word accesses: byte enables and replicated
// store data on the way out, lane extraction plus sign/zero extension on the way in.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  datatype,
    input  logic        unsigned_ld,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        // NOTE: every output is given a default first, so no path through the case can infer a latch.
        byte_en     = 4'b1111;
        store_lanes = store_data;
        load_data   = load_word;
        lane16      = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        case (addr_lo)
            2'd0:    lane8 = load_word[7:0];
            2'd1:    lane8 = load_word[15:8];
            2'd2:    lane8 = load_word[23:16];
            default: lane8 = load_word[31:24];
        endcase

        // Datatype 2'b11 falls through to the word defaults.
        case (datatype)
            DT_BYTE: begin
                byte_en     = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = {{24{lane8[7] & ~unsigned_ld}}, lane8};
            end
            DT_HALF: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = {{16{lane16[15] & ~unsigned_ld}}, lane16};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: issues one handshaked request per load/store,
// stalls the upstream pipeline registers until the ack, then presents the load result.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [31:0]       MEM_ALUResult,
    input  logic [31:0]       MEM_ReadData2,
    input  logic [1:0]        MEM_Datatype,
    input  logic [31:0]       MEM_Instruction,
    output logic              DM_Req,
    output logic              DM_We,
    output logic [ADDR_W-1:0] DM_Addr,
    output logic [3:0]        DM_ByteEn,
    output logic [31:0]       DM_WData,
    input  logic [31:0]       DM_RData,
    input  logic              DM_Ack,
    output logic [31:0]       MEM_ReadData,
    output logic              Stall,
    output logic              Misaligned
);

    state_t      state;
    logic        is_mem_op;
    logic        is_half;
    logic        is_word;
    logic        access;
    logic [3:0]  lane_byte_en;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^{MEM_Instruction[31:UNSIGNED_BIT+1], MEM_Instruction[UNSIGNED_BIT-1:0]};

    assign is_mem_op  = MEM_MemRead | MEM_MemWrite;
    assign is_half    = (MEM_Datatype == DT_HALF);
    assign is_word    = (MEM_Datatype != DT_HALF) && (MEM_Datatype != DT_BYTE);
    assign Misaligned = is_mem_op & ((is_half & MEM_ALUResult[0]) | (is_word & (|MEM_ALUResult[1:0])));
    assign access     = is_mem_op & ~Misaligned;
    assign Stall      = access & (state != DONE);

    // The EX/MEM register is frozen by Stall, so the live inputs still describe
    // the in-flight access when the ack arrives and can drive the load path too.
    mem_lane_align u_lane_align (
        .addr_lo     (MEM_ALUResult[1:0]),
        .datatype    (MEM_Datatype),
        .unsigned_ld (MEM_Instruction[UNSIGNED_BIT]),
        .store_data  (MEM_ReadData2),
        .load_word   (DM_RData),
        .byte_en     (lane_byte_en),
        .store_lanes (lane_wdata),
        .load_data   (lane_rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            // NOTE: non-blocking assignments throughout, and every register here is cleared so a reset mid-request abandons it cleanly.
            state        <= IDLE;
            DM_Req       <= 1'b0;
            DM_We        <= 1'b0;
            DM_Addr      <= '0;
            DM_ByteEn    <= '0;
            DM_WData     <= '0;
            MEM_ReadData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        DM_Req    <= 1'b1;
                        DM_We     <= MEM_MemWrite;
                        DM_Addr   <= {MEM_ALUResult[ADDR_W-1:2], 2'b00};
                        DM_ByteEn <= lane_byte_en;
                        DM_WData  <= lane_wdata;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (DM_Ack) begin
                        DM_Req <= 1'b0;
                        if (!DM_We) begin
                            MEM_ReadData <= lane_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
